// File: rtl/dma_copy_master.sv
// dma_copy_master: a bus master that copies a block of words from one
// address range to another. Each word is read and then written back, and
// the master holds its bus request for the whole block.
//
// Bus handshake (one rule for every bus cycle):
//   The master raises m_req and keeps it high from REQ through the last WR.
//   A bus cycle takes effect only in a cycle where both m_req and m_grant are
//   high. A read address shown in RD returns data on m_din in the following
//   cycle (RD_WAIT). A write takes effect in the WR cycle when m_grant is high.
//   If m_grant is low in RD, RD_WAIT or WR, the current word is abandoned and
//   restarts from its read once the bus is granted again.
module dma_copy_master #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_address,
  output logic [DW-1:0] m_dout,
  input  logic          m_grant,
  input  logic [DW-1:0] m_din
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] count;

  // Copy sequencer. All bus-side outputs are registered and change together
  // with the state. m_dout doubles as the word buffer: it is loaded from
  // m_din when the read completes and then held until the next read
  // completes, so it keeps the last written value outside WR.
  // Address arithmetic wraps naturally at 2^AW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_address <= '0;
      m_dout    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src   <= src_addr;
            dst   <= dst_addr;
            count <= length;
            if (length == '0) begin
              // Nothing to copy: finish without touching the bus.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= REQ;
              m_req <= 1'b1;
              m_wr  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end

        REQ: begin
          if (m_grant) begin
            state     <= RD;
            m_address <= src;
            m_wr      <= 1'b0;
          end
        end

        RD: begin
          if (!m_grant) begin
            state <= REQ;
          end else begin
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (!m_grant) begin
            state <= REQ;
          end else begin
            state     <= WR;
            m_dout    <= m_din;
            m_address <= dst;
            m_wr      <= 1'b1;
          end
        end

        WR: begin
          if (!m_grant) begin
            // Write did not land; the word is redone from its read.
            state <= REQ;
            m_wr  <= 1'b0;
          end else if (count == LW'(1)) begin
            state <= DONE;
            m_req <= 1'b0;
            m_wr  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            src       <= src + AW'(1);
            dst       <= dst + AW'(1);
            count     <= count - LW'(1);
            state     <= RD;
            m_address <= src + AW'(1);
            m_wr      <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          m_req <= 1'b0;
          m_wr  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dma_copy_master.md
Name: dma_copy_master

Overview:
- Bus master that copies a block of 32-bit words from one slave address range to another.
- Sits directly upstream of the two-master/two-slave bus and drives one master port (m0 or m1) with req/wr/address/dout; consumes grant and m_din.
- Started by a one-cycle pulse from the control side; signals completion with a one-cycle done pulse.

Parameters:
- AW, 8, bus address width
- DW, 32, bus data width
- LW, 8, transfer length counter width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle start pulse; sampled only in IDLE
- src_addr  input  AW  first source address; latched on accepted start
- dst_addr  input  AW  first destination address; latched on accepted start
- length  input  LW  number of words to copy; latched on accepted start
- busy  output  1  high from the cycle after accepted start until DONE
- done  output  1  one-cycle completion pulse
- m_req  output  1  bus request to arbiter
- m_wr  output  1  1 = write, 0 = read
- m_address  output  AW  bus address
- m_dout  output  DW  write data to bus
- m_grant  input  1  grant from arbiter
- m_din  input  DW  read data from bus; valid one cycle after read address is presented

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - m_req = 0, m_wr = 0, m_address = 0, m_dout = 0, busy = 0, done = 0.
  - Internal src/dst/count/buffer registers cleared.
  - Reset mid-transfer aborts immediately; no done pulse is issued.
- States: IDLE, REQ, RD, RD_WAIT, WR, DONE.
- IDLE:
  - On start=1, latch src_addr, dst_addr, length.
  - If length = 0, go to DONE.
  - Otherwise go to REQ.
- REQ:
  - m_req = 1, m_wr = 0, busy = 1.
  - On m_grant = 1, go to RD.
- RD:
  - m_address = current src, m_wr = 0.
  - Always go to RD_WAIT next edge.
- RD_WAIT:
  - m_address holds src, m_wr = 0.
  - At the edge, capture m_din into buffer and go to WR.
- WR:
  - m_address = current dst, m_wr = 1, m_dout = buffer.
  - At the edge: if count = 1, go to DONE.
  - Otherwise src+1, dst+1, count-1, and go to RD.
- DONE:
  - m_req = 0, m_wr = 0, busy = 0, done = 1 for exactly one cycle.
  - Go to IDLE.
- m_req stays 1 continuously from REQ through the last WR; the master holds the bus for the whole block.
- Throughput: 3 cycles per word once granted.
  - Total cycles from start to done = 1 (REQ, if immediately granted) + 3·length + 1.
- Grant loss: if m_grant = 0 in RD, RD_WAIT or WR:
  - Return to REQ with no increment.
  - The current word restarts from its read; a partial write is never counted.
- Address arithmetic: src and dst increment modulo 2^AW (0xFF → 0x00); no error on wrap.
- length = 0: no bus activity; done pulses on the cycle after start.
- start while busy: ignored; latched parameters are unchanged.
- start in the same cycle as done: ignored (state is not IDLE).
- m_dout is held at the last written value outside WR; m_address holds the last value in IDLE.

Test Plan:
- Reset mid-transfer: assert reset during WR of word 1 → m_req = 0, busy = 0 immediately; no done; next start works normally.
- Basic copy: preload s0 at 0x01..0x04 with 0x11111111..0x44444444; start with src = 0x01, dst = 0x21, length = 4, m_grant tied 1 → s1 at 0x21..0x24 holds 0x11111111..0x44444444; done exactly 14 cycles after start; busy high for 13 cycles.
- Zero length: start with length = 0 → done on the next cycle; m_req never rises.
- Grant delay and loss:
  - Hold m_grant = 0 for 5 cycles after start → m_req stays 1 and no read is issued; copy of 2 words then completes.
  - Drop m_grant for one cycle during RD_WAIT of word 2 → word 2 is re-read and written once; destination data is correct.
- Address wrap: src = 0xFE, dst = 0x3E, length = 3 → reads 0xFE, 0xFF, 0x00; writes 0x3E, 0x3F, 0x40.
- Start while busy: pulse start with new params during transfer → ignored; original transfer completes unchanged and exactly one done pulse is seen.
